// File: rtl/tgl_hs_pkg.sv
// Shared types and default parameters for the toggle-handshake receiver.
package tgl_hs_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/tgl_sync.sv
// Multi-flop synchroniser for a toggle signal, with a one-cycle delayed copy
// used to turn each level change into a single-cycle event.
module tgl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl_in,
    output logic tgl_s,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Next-state for the synchroniser chain and the delayed copy
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tgl_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delayed-copy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign tgl_s    = sync_q[SYNC_STAGES-1];
    assign edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/tgl_hs_rx.sv
// Receiving end of a two-phase toggle handshake: captures one word per req
// toggle, offers it on valid/ready and toggles ack once it has been consumed.
module tgl_hs_rx
    import tgl_hs_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  evt_count,
    output logic              proto_err
);

    logic req_s;
    logic req_edge_s;

    tgl_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk      (clk),
        .rst_n    (clear_n),
        .tgl_in   (req_tgl),
        .tgl_s    (req_s),
        .edge_det (req_edge_s)
    );

    state_t            state_q,     state_d;
    logic              ack_q,       ack_d;
    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              err_q,       err_d;

    // Capture/consume state machine; a toggle seen while full is dropped
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_edge_s) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = FULL;
                end else begin
                    valid_d = 1'b0;
                end
            end
            FULL: begin
                if (req_edge_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ack_tgl   = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign evt_count = cnt_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_tgl_hs_rx.sv
// Randomised and directed bench for tgl_hs_rx against an event-level model.
module tb_tgl_hs_rx;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       req_tgl;
    logic [7:0] data_in;
    logic       ack_tgl;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [7:0] evt_count;
    logic       proto_err;

    tgl_hs_rx #(
        .DATA_W(8),
        .SYNC_STAGES(2),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .req_tgl   (req_tgl),
        .data_in   (data_in),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .evt_count (evt_count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Model: each toggle becomes an event a fixed number of edges later
    int         arrivals[$];
    bit         m_valid;
    bit         m_ack;
    bit         m_err;
    logic [7:0] m_data;
    int         m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        arrivals.delete();
        m_valid = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_data  = 8'h00;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        bit ev;
        ev = 1'b0;
        if (arrivals.size() > 0 && arrivals[0] == cyc) begin
            ev = 1'b1;
            void'(arrivals.pop_front());
        end
        if (m_valid) begin
            if (ev) m_err = 1'b1;
            if (out_ready) begin
                m_valid = 1'b0;
                m_ack   = ~m_ack;
            end
        end else if (ev) begin
            m_valid = 1'b1;
            m_data  = data_in;
            m_cnt   = (m_cnt + 1) % 256;
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("ack_tgl",   32'(ack_tgl),   32'(m_ack));
        chk("evt_count", 32'(evt_count), 32'(m_cnt));
        chk("proto_err", 32'(proto_err), 32'(m_err));
    endtask

    // Called just after an edge: drive inputs, advance one edge, compare
    task automatic step(input bit tog, input logic [7:0] d, input bit rdy);
        if (tog) begin
            req_tgl = ~req_tgl;
            arrivals.push_back(cyc + 2 + 1);
        end
        data_in   = d;
        out_ready = rdy;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        req_tgl = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ack",   32'(ack_tgl),   32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_cnt",   32'(evt_count), 32'd0);
        chk("rst_err",   32'(proto_err), 32'd0);
        clear_n = 1'b1;
    endtask

    logic       ack_hold;
    logic [7:0] rd;

    initial begin
        data_in   = 8'h00;
        out_ready = 1'b0;
        do_reset();

        // Idle with static req
        repeat (10) step(1'b0, 8'h00, 1'b0);

        // Single word, 3-edge latency then immediate consume
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'hA5, 1'b1);
        step(1'b0, 8'hA5, 1'b1);
        chk("sw_valid", 32'(out_valid), 32'd1);
        chk("sw_data",  32'(out_data),  32'hA5);
        step(1'b0, 8'hA5, 1'b1);
        chk("sw_valid_lo", 32'(out_valid), 32'd0);
        chk("sw_ack",      32'(ack_tgl),   32'd1);
        chk("sw_cnt",      32'(evt_count), 32'd1);

        // Back-pressure
        step(1'b1, 8'h3C, 1'b0);
        repeat (22) step(1'b0, 8'h3C, 1'b0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ack",   32'(ack_tgl),   32'd1);
        step(1'b0, 8'h3C, 1'b1);
        chk("bp_ack_tgl", 32'(ack_tgl), 32'd0);

        // Both polarities
        step(1'b1, 8'h01, 1'b1);
        repeat (4) step(1'b0, 8'h01, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        repeat (2) step(1'b0, 8'h02, 1'b1);
        chk("pol_data", 32'(out_data), 32'h02);
        repeat (2) step(1'b0, 8'h02, 1'b1);
        chk("pol_cnt", 32'(evt_count), 32'd4);

        // Protocol violation
        step(1'b1, 8'h11, 1'b0);
        repeat (4) step(1'b0, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        repeat (4) step(1'b0, 8'h22, 1'b0);
        chk("pv_err",  32'(proto_err), 32'd1);
        chk("pv_data", 32'(out_data),  32'h11);
        chk("pv_cnt",  32'(evt_count), 32'd5);
        repeat (6) step(1'b0, 8'h22, 1'b1);
        chk("pv_valid", 32'(out_valid), 32'd0);

        // Count wrap after 256 words
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rd = 8'($urandom);
            step(1'b1, rd, 1'b1);
            repeat (3) step(1'b0, rd, 1'b1);
        end
        chk("wrap_cnt", 32'(evt_count), 32'd0);
        chk("wrap_err", 32'(proto_err), 32'd0);

        // Random traffic, mostly legal with occasional early toggles
        do_reset();
        rd = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            bit tog;
            tog = ($urandom_range(0, 5) == 0);
            if (tog) rd = 8'($urandom);
            step(tog, rd, 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset while full, between edges
        step(1'b1, 8'h5A, 1'b0);
        repeat (3) step(1'b0, 8'h5A, 1'b0);
        chk("ar_full", 32'(out_valid), 32'd1);
        #2;
        clear_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ack",   32'(ack_tgl),   32'd0);
        chk("ar_cnt",   32'(evt_count), 32'd0);
        do_reset();
        repeat (5) step(1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
